encoder_speed_meter: RTL and testbench

- Converts one wheel's quadrature encoder (A/B) into a signed angular-velocity word in rad/s, fixed point N_WIDTH bits with Q_WIDTH fraction bits.
- Four instances sit directly upstream of the odometry calculator and drive its W1..W4 speed inputs.
- Per instance: synchronizer, x4 quadrature decoder, fixed-window edge counter, 2-stage scale/saturate pipeline.

---
 rtl/encoder_speed_meter.sv | 160 ++++++++++++++++
 tb/tb_encoder_speed_meter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/encoder_speed_meter.sv
// Quadrature encoder to signed angular velocity (rad/s, Q_WIDTH fraction bits), one window per update.
// Optional macro ENCODER_SPEED_FILTER_EN averages each published sample with the previous one.
module encoder_speed_meter #(
    parameter int N_WIDTH      = 17,
    parameter int Q_WIDTH      = 8,
    parameter int COUNT_WIDTH  = 16,
    parameter int SAMPLE_TICKS = 500000,
    parameter int K_GAIN       = 28595,
    parameter int K_SHIFT      = 8
) (
    input  logic               ENCODER_SPEED_CLOCK_50,
    input  logic               ENCODER_SPEED_Reset_InHigh,
    input  logic               ENCODER_SPEED_A_In,
    input  logic               ENCODER_SPEED_B_In,
    output logic [N_WIDTH-1:0] ENCODER_SPEED_W_OutBus,
    output logic               ENCODER_SPEED_VALID_Out,
    output logic               ENCODER_SPEED_ERR_Out
);

    localparam int TICK_W   = $clog2(SAMPLE_TICKS);
    localparam int PROD_W   = COUNT_WIDTH + 17;
    localparam int INT_BITS = N_WIDTH - Q_WIDTH;

    localparam logic signed [PROD_W-1:0] W_MAX = PROD_W'((2 ** (INT_BITS + Q_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] W_MIN = PROD_W'(-(2 ** (INT_BITS + Q_WIDTH - 1)));
    localparam logic signed [COUNT_WIDTH:0] CNT_MAX = (COUNT_WIDTH+1)'((2 ** (COUNT_WIDTH - 1)) - 1);
    localparam logic signed [COUNT_WIDTH:0] CNT_MIN = (COUNT_WIDTH+1)'(-(2 ** (COUNT_WIDTH - 1)));
    localparam logic signed [PROD_W-1:0] K_EXT = PROD_W'(K_GAIN);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SAMPLE_TICKS - 1);

    typedef enum logic [1:0] {S_COUNT, S_SCALE, S_PUBLISH} seqState_t;

    logic [1:0] syncA, syncB;
    logic [1:0] prevAb, curAb;
    logic signed [1:0] delta;
    logic illegal;

    logic [TICK_W-1:0] tick;
    logic windowEnd;
    logic signed [COUNT_WIDTH-1:0] edgeCount, nextCount, latchCount;
    logic signed [COUNT_WIDTH:0] countSum;

    logic signed [PROD_W-1:0] product, latchExt, shifted;
    logic signed [N_WIDTH-1:0] satCur, pubVal;
    seqState_t state;

    // Position around the 00->10->11->01 cycle; forward motion increments it mod 4.
    function automatic logic [1:0] grayIdx(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    assign curAb = {syncA[1], syncB[1]};

    always_comb begin
        delta   = 2'sd0;
        illegal = 1'b0;
        if (curAb != prevAb) begin
            if ((curAb ^ prevAb) == 2'b11)
                illegal = 1'b1;
            else if (grayIdx(curAb) == grayIdx(prevAb) + 2'd1)
                delta = 2'sd1;
            else
                delta = -2'sd1;
        end
    end

    // The delta decoded in the window-end cycle still belongs to the closing window.
    always_comb begin
        countSum = {edgeCount[COUNT_WIDTH-1], edgeCount}
                 + {{(COUNT_WIDTH-1){delta[1]}}, delta};
        if (countSum > CNT_MAX)
            nextCount = CNT_MAX[COUNT_WIDTH-1:0];
        else if (countSum < CNT_MIN)
            nextCount = CNT_MIN[COUNT_WIDTH-1:0];
        else
            nextCount = countSum[COUNT_WIDTH-1:0];
    end

    assign windowEnd = (tick == LAST_TICK);
    assign latchExt  = {{(PROD_W-COUNT_WIDTH){latchCount[COUNT_WIDTH-1]}}, latchCount};
    assign shifted   = product >>> K_SHIFT;

    always_comb begin
        if (shifted > W_MAX)
            satCur = W_MAX[N_WIDTH-1:0];
        else if (shifted < W_MIN)
            satCur = W_MIN[N_WIDTH-1:0];
        else
            satCur = shifted[N_WIDTH-1:0];
    end

`ifdef ENCODER_SPEED_FILTER_EN
    logic signed [N_WIDTH-1:0] satPrev;
    logic signed [N_WIDTH:0]   avgSum;

    // One guard bit keeps the sum of two saturated extremes from overflowing.
    assign avgSum = {satCur[N_WIDTH-1], satCur} + {satPrev[N_WIDTH-1], satPrev};
    assign pubVal = N_WIDTH'(avgSum >>> 1);

    always_ff @(posedge ENCODER_SPEED_CLOCK_50) begin
        if (ENCODER_SPEED_Reset_InHigh)
            satPrev <= '0;
        else if (state == S_PUBLISH)
            satPrev <= satCur;
    end
`else
    assign pubVal = satCur;
`endif

    always_ff @(posedge ENCODER_SPEED_CLOCK_50) begin
        if (ENCODER_SPEED_Reset_InHigh) begin
            syncA                   <= 2'b00;
            syncB                   <= 2'b00;
            prevAb                  <= 2'b00;
            tick                    <= '0;
            edgeCount               <= '0;
            latchCount              <= '0;
            product                 <= '0;
            state                   <= S_COUNT;
            ENCODER_SPEED_W_OutBus  <= '0;
            ENCODER_SPEED_VALID_Out <= 1'b0;
            ENCODER_SPEED_ERR_Out   <= 1'b0;
        end else begin
            syncA  <= {syncA[0], ENCODER_SPEED_A_In};
            syncB  <= {syncB[0], ENCODER_SPEED_B_In};
            prevAb <= curAb;

            if (illegal)
                ENCODER_SPEED_ERR_Out <= 1'b1;

            if (windowEnd) begin
                tick       <= '0;
                edgeCount  <= '0;
                latchCount <= nextCount;
            end else begin
                tick      <= tick + 1'b1;
                edgeCount <= nextCount;
            end

            ENCODER_SPEED_VALID_Out <= 1'b0;
            case (state)
                S_COUNT: begin
                    if (windowEnd)
                        state <= S_SCALE;
                end
                S_SCALE: begin
                    product <= latchExt * K_EXT;
                    state   <= S_PUBLISH;
                end
                S_PUBLISH: begin
                    ENCODER_SPEED_W_OutBus  <= pubVal;
                    ENCODER_SPEED_VALID_Out <= 1'b1;
                    state                   <= S_COUNT;
                end
                default: state <= S_COUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_speed_meter.sv
// Bench for encoder_speed_meter: vector table of step bursts plus hand-written window-edge,
// mid-window-reset and illegal-transition sequences, scored through an expected-value queue.
module tb_encoder_speed_meter;

    localparam int S = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic [16:0] w;
    logic        valid;
    logic        err;

    always #10 clk = ~clk;

    encoder_speed_meter #(.SAMPLE_TICKS(S)) dut (
        .ENCODER_SPEED_CLOCK_50    (clk),
        .ENCODER_SPEED_Reset_InHigh(rst),
        .ENCODER_SPEED_A_In        (a),
        .ENCODER_SPEED_B_In        (b),
        .ENCODER_SPEED_W_OutBus    (w),
        .ENCODER_SPEED_VALID_Out   (valid),
        .ENCODER_SPEED_ERR_Out     (err)
    );

    // Cycle index inside the run; cycle 0 is the first one after reset is released.
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int expQ[$];
    int prevRaw = 0;
    int gidx = 0;

    typedef struct {
        int n;
        bit fwd;
        int raw;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: floor(count*28595/256) saturated to 17 bits, optionally averaged with the previous window.
    task automatic expectRaw(input int raw);
`ifdef ENCODER_SPEED_FILTER_EN
        expQ.push_back((raw + prevRaw) >>> 1);
        prevRaw = raw;
`else
        expQ.push_back(raw);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && valid) begin
            check("valid_phase", cyc % S, 2);
            if (expQ.size() == 0)
                check("unexpected_valid", 1, 0);
            else
                check("w_out", int'($signed(w)), expQ.pop_front());
        end
    end

    task automatic driveIdx(input int idx);
        case (idx)
            0: begin a = 1'b0; b = 1'b0; end
            1: begin a = 1'b1; b = 1'b0; end
            2: begin a = 1'b1; b = 1'b1; end
            default: begin a = 1'b0; b = 1'b1; end
        endcase
    endtask

    task automatic doReset();
        a = 1'b0;
        b = 1'b0;
        gidx = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        prevRaw = 0;
        expQ.delete();
    endtask

    task automatic steps(input int n, input bit fwd);
        for (int i = 0; i < n; i++) begin
            gidx = fwd ? (gidx + 1) % 4 : (gidx + 3) % 4;
            driveIdx(gidx);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitCyc(input int c);
        int budget;
        budget = 4 * S;
        while (cyc < c && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (cyc < c) check("wait_timeout", cyc, c);
    endtask

    task automatic drain();
        int budget;
        budget = 4 * S;
        while (expQ.size() > 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (expQ.size() > 0) check("drain_timeout", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{100, 1'b1, 11169},
            '{100, 1'b0, -11170},
            '{0,   1'b1, 0},
            '{600, 1'b1, 65535},
            '{600, 1'b0, -65536},
            '{1,   1'b1, 111},
            '{1,   1'b0, -112}
        };

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_w", int'(w), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(err), 0);

        // Table: burst in window 1, idle window 2
        for (int v = 0; v < 7; v++) begin
            doReset();
            expectRaw(vecs[v].raw);
            expectRaw(0);
            steps(vecs[v].n, vecs[v].fwd);
            drain();
            @(negedge clk);
            check("err_clean", int'(err), 0);
        end

        // Partial count before a mid-window reset is discarded
        doReset();
        steps(50, 1'b1);
        doReset();
        expectRaw(11169);
        expectRaw(0);
        steps(100, 1'b1);
        drain();

        // Edge decoded in the window-end cycle, then one in the following cycle
        doReset();
        expectRaw(111);
        expectRaw(111);
        waitCyc(S - 3);
        driveIdx(1);
        @(posedge clk);
        #1;
        driveIdx(2);
        drain();

        // Illegal jump: count untouched, ERR sticky across windows until reset
        doReset();
        expectRaw(11169);
        expectRaw(11169);
        steps(100, 1'b1);
        a = 1'b1;
        b = 1'b1;
        gidx = 2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("err_set", int'(err), 1);
        waitCyc(S + 5);
        steps(100, 1'b1);
        drain();
        @(negedge clk);
        check("err_sticky", int'(err), 1);
        a = 1'b0;
        b = 1'b1;
        repeat (3) @(posedge clk);
        a = 1'b0;
        b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        prevRaw = 0;
        @(negedge clk);
        check("post_reset_w", int'(w), 0);
        check("post_reset_valid", int'(valid), 0);
        check("post_reset_err", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
